// File: rtl/subleq_loader_pkg.sv
// subleq_loader_pkg: shared types for the boot loader.
// Word/address width, byte width, loader state encoding, and a helper that
// tells whether a state consumes host bytes.
package subleq_loader_pkg;

  localparam int WORD_SIZE = 16;
  localparam int BYTE_W    = 8;

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [BYTE_W-1:0]    byte_t;

  typedef enum logic [2:0] {
    LD_ADDR_HI = 3'd0,
    LD_ADDR_LO = 3'd1,
    LD_CNT_HI  = 3'd2,
    LD_CNT_LO  = 3'd3,
    LD_DATA_HI = 3'd4,
    LD_DATA_LO = 3'd5,
    LD_WRITE   = 3'd6,
    LD_DONE    = 3'd7
  } ld_state_t;

  // Every state except the write strobe and the terminal state takes a byte.
  function automatic logic is_byte_state(input ld_state_t s);
    return (s != LD_WRITE) && (s != LD_DONE);
  endfunction

endpackage

// File: rtl/subleq_loader_if.sv
// subleq_loader_if: host byte link, memory write port and CPU control of the loader.
// master = loader side (accepts bytes, drives memory writes and CPU hold).
// slave  = environment side (host byte source, memory, CPU).
interface subleq_loader_if;
  import subleq_loader_pkg::*;

  byte_t rx_data;    // incoming byte
  logic  rx_valid;   // rx_data valid this cycle
  logic  rx_ready;   // loader accepts rx_data this cycle
  word_t mem_addr;   // memory write address
  word_t mem_wdata;  // memory write data
  logic  mem_we;     // one-cycle write strobe
  logic  cpu_hold;   // CPU reset request, high until load complete
  logic  load_done;  // sticky, high once end marker consumed

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_addr, mem_wdata, mem_we, cpu_hold, load_done
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_addr, mem_wdata, mem_we, cpu_hold, load_done
  );

endinterface

// File: rtl/subleq_loader.sv
// subleq_loader: boot loader turning ADDR/CNT-framed big-endian byte segments into memory word writes.
// Latency: write strobe one cycle after the low data byte; 1 word per 3 cycles at best.
// Backpressure: rx_ready drops only in the WRITE cycle and forever after the end marker.
// Ports: clk, areset (async, active-high); bus (subleq_loader_if.master): rx_data/rx_valid/rx_ready,
//   mem_addr/mem_wdata/mem_we, cpu_hold, load_done.
module subleq_loader
  import subleq_loader_pkg::*;
(
  input  logic           clk,
  input  logic           areset,
  subleq_loader_if.master bus
);

  ld_state_t state_q, state_d;

  byte_t hi_q;         // high byte held until its low partner arrives
  word_t addr_q;       // next write address, post-incremented per word
  word_t remaining_q;  // words still to write in the current segment
  word_t wr_addr_q;    // registered write port
  word_t wr_data_q;
  logic  hold_q;
  logic  done_q;

  logic  xfer;
  word_t rx_word;

  assign bus.rx_ready  = is_byte_state(state_q);
  assign xfer          = bus.rx_valid & bus.rx_ready;
  assign rx_word       = {hi_q, bus.rx_data};

  assign bus.mem_we    = (state_q == LD_WRITE);
  assign bus.mem_addr  = wr_addr_q;
  assign bus.mem_wdata = wr_data_q;
  assign bus.cpu_hold  = hold_q;
  assign bus.load_done = done_q;

  // State register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= LD_ADDR_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: byte states move only on a transfer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LD_ADDR_HI: if (xfer) state_d = LD_ADDR_LO;
      LD_ADDR_LO: if (xfer) state_d = LD_CNT_HI;
      LD_CNT_HI:  if (xfer) state_d = LD_CNT_LO;
      // A zero count is the end marker; the segment address is simply dropped.
      LD_CNT_LO:  if (xfer) state_d = (rx_word == '0) ? LD_DONE : LD_DATA_HI;
      LD_DATA_HI: if (xfer) state_d = LD_DATA_LO;
      LD_DATA_LO: if (xfer) state_d = LD_WRITE;
      // remaining_q still holds the pre-decrement count here.
      LD_WRITE:   state_d = (remaining_q == word_t'(1)) ? LD_ADDR_HI : LD_DATA_HI;
      LD_DONE:    state_d = LD_DONE;
      default:    state_d = LD_ADDR_HI;
    endcase
  end

  // Datapath: byte assembly, address/count tracking, write port, status
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      hi_q        <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      hold_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      if (xfer) begin
        unique case (state_q)
          LD_ADDR_HI, LD_CNT_HI, LD_DATA_HI: hi_q <= bus.rx_data;
          LD_ADDR_LO: addr_q      <= rx_word;
          LD_CNT_LO:  remaining_q <= rx_word;
          LD_DATA_LO: begin
            wr_addr_q <= addr_q;
            wr_data_q <= rx_word;
          end
          default: ;
        endcase
      end

      // Address wraps naturally at the word width; a segment may cross 0xFFFF.
      if (state_q == LD_WRITE) begin
        addr_q      <= addr_q + word_t'(1);
        remaining_q <= remaining_q - word_t'(1);
      end

      // Released one cycle after reaching DONE, both flags together.
      if (state_q == LD_DONE) begin
        hold_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_subleq_loader.sv
// tb_subleq_loader: randomized self-checking bench for subleq_loader.
// Builds byte streams from segment descriptions and predicts the ordered write list
// directly from the framing rules, then compares against observed write strobes.
module tb_subleq_loader;
  import subleq_loader_pkg::*;

  logic clk = 1'b0;
  logic areset;

  always #5 clk = ~clk;

  subleq_loader_if bus ();

  subleq_loader u_dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;
  int inv_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: stream bytes and expected writes
  byte_t stream[$];
  word_t exp_addr[$];
  word_t exp_data[$];
  word_t cur_addr;

  task automatic seg(input word_t a, input word_t c);
    stream.push_back(a[15:8]);
    stream.push_back(a[7:0]);
    stream.push_back(c[15:8]);
    stream.push_back(c[7:0]);
    cur_addr = a;
  endtask

  task automatic word(input word_t w);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
    exp_addr.push_back(cur_addr);
    exp_data.push_back(w);
    cur_addr = cur_addr + 16'd1;
  endtask

  task automatic clear_model();
    stream.delete();
    exp_addr.delete();
    exp_data.delete();
    cur_addr = '0;
  endtask

  // Observed writes and protocol invariants
  word_t got_addr[$];
  word_t got_data[$];
  logic  pend_low = 1'b0;

  always @(negedge clk) begin
    if (areset) begin
      pend_low = 1'b0;
    end else begin
      if (bus.mem_we) begin
        got_addr.push_back(bus.mem_addr);
        got_data.push_back(bus.mem_wdata);
      end
      // rx_ready low without a write is only allowed on the way into DONE
      if (pend_low && !bus.load_done) inv_err++;
      pend_low = !bus.rx_ready && !bus.mem_we && !bus.load_done;
      if (bus.rx_ready && (bus.mem_we || bus.load_done)) inv_err++;
      if (bus.cpu_hold == bus.load_done) inv_err++;
    end
  end

  task automatic send_byte(input byte_t b, input int idle_pct);
    int   n;
    logic ok;
    while (idle_pct > 0 && int'($urandom_range(99)) < idle_pct) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = byte_t'($urandom);
      @(posedge clk); #1;
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    forever begin
      ok = bus.rx_ready;
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n > 20) begin
        check("rx_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_stream(input int idle_pct);
    foreach (stream[i]) send_byte(stream[i], idle_pct);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    bus.rx_valid = 1'b0;
    areset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_rst_rx_ready"},  32'(bus.rx_ready),  32'd1);
    check({tag, "_rst_mem_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_rst_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_rst_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_rst_cpu_hold"},  32'(bus.cpu_hold),  32'd1);
    check({tag, "_rst_load_done"}, 32'(bus.load_done), 32'd0);
    areset = 1'b0;
  endtask

  task automatic start_test(input string tag);
    do_reset(tag);
    got_addr.delete();
    got_data.delete();
    clear_model();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
    end
  endtask

  task automatic check_done(input string tag);
    check({tag, "_load_done"}, 32'(bus.load_done), 32'd1);
    check({tag, "_cpu_hold"},  32'(bus.cpu_hold),  32'd0);
    check({tag, "_rx_ready"},  32'(bus.rx_ready),  32'd0);
  endtask

  task automatic build_t1();
    seg(16'h0010, 16'd2);
    word(16'h1234);
    word(16'hABCD);
    seg(16'h0000, 16'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset       = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;

    // Test 1: basic two-word segment
    start_test("t1");
    build_t1();
    send_stream(0);
    check_writes("t1");
    check_done("t1");

    // Test 2: two single-word segments
    start_test("t2");
    seg(16'h0000, 16'd1); word(16'h0001);
    seg(16'h0100, 16'd1); word(16'hFFFF);
    seg(16'h0000, 16'd0);
    send_stream(0);
    check_writes("t2");
    check_done("t2");

    // Test 3: address wrap across 0xFFFF
    start_test("t3");
    seg(16'hFFFF, 16'd2); word(16'h1111); word(16'h2222);
    seg(16'h0000, 16'd0);
    send_stream(0);
    check_writes("t3");
    check_done("t3");

    // Test 4: immediate end marker, further bytes ignored
    start_test("t4");
    seg(16'h0000, 16'd0);
    send_stream(0);
    check_done("t4");
    for (int i = 0; i < 10; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = byte_t'($urandom);
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
    check_writes("t4");
    check_done("t4_after");

    // Test 5: test 1 stream with random idle gaps
    start_test("t5");
    build_t1();
    send_stream(30);
    check_writes("t5");
    check_done("t5");

    // Test 6: reset after the first data high byte, then replay
    start_test("t6");
    build_t1();
    for (int i = 0; i < 5; i++) send_byte(stream[i], 0);
    @(posedge clk); #1;
    do_reset("t6_abort");
    check("t6_abort_nwrites", 32'(got_addr.size()), 32'd0);
    send_stream(0);
    check_writes("t6");
    check_done("t6");

    // Randomized segments, end-marker address random, overlap allowed
    for (int r = 0; r < 4; r++) begin
      start_test($sformatf("rnd%0d", r));
      for (int s = 0; s < 3; s++) begin
        int    cnt;
        word_t a;
        cnt = int'($urandom_range(6, 1));
        a = (s == 0) ? word_t'($urandom_range(16'hFFFF, 16'hFFFC)) : word_t'($urandom);
        seg(a, word_t'(cnt));
        for (int w = 0; w < cnt; w++) word(word_t'($urandom));
      end
      seg(word_t'($urandom), 16'd0);
      send_stream(30);
      check_writes($sformatf("rnd%0d", r));
      check_done($sformatf("rnd%0d", r));
    end

    check("protocol_invariants", 32'(inv_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
